// File: rtl/zigzag_sram_arbiter.sv
// zigzag_sram_arbiter
// Shares the single external 8-bit SRAM between the program-ROM fetch path,
// the graphics-ROM fetch path and a periodic poll of the SCANDBLCTRL image.
// One access at a time: IDLE -> ACCESS (WAIT_CYCLES clocks) -> DONE -> IDLE.
//
// state  | meaning
// IDLE   | arbitrate; latch winner and its address on a grant
// ACCESS | address held on the SRAM; count down, capture data at zero
// DONE   | one cycle for the requester to drop its req before re-arbitration

module zigzag_sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned POLL_DIV    = 1024,
  parameter int unsigned STARVE      = 255,
  parameter logic [18:0] CFG_ADDR    = 19'h08FD5
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        prg_req,
  input  logic        prg_bank,
  input  logic [14:0] prg_addr,
  output logic        prg_ack,
  output logic [7:0]  prg_data,
  input  logic        gfx_req,
  input  logic        gfx_bank,
  input  logic [13:0] gfx_addr,
  output logic        gfx_ack,
  output logic [7:0]  gfx_data,
  output logic [18:0] sram_addr,
  input  logic [7:0]  sram_data,
  output logic        sram_we_n,
  output logic [1:0]  scandblctrl,
  output logic        cfg_valid,
  output logic        busy
);

  localparam int PW = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
  typedef enum logic [1:0] {G_PRG, G_GFX, G_CFG} grant_t;

  state_t      state_q;
  grant_t      grant_q;
  logic [3:0]  wait_q;
  logic        dropped_q;
  logic [18:0] sram_addr_q;
  logic        prg_ack_q, gfx_ack_q;
  logic [7:0]  prg_data_q, gfx_data_q;
  logic [1:0]  scandbl_q;
  logic        cfg_valid_q;

  logic [PW-1:0] poll_q;
  logic [7:0]    age_q;
  logic          cfg_pend_q;

  logic          poll_tc;
  logic          cfg_urgent;
  logic          cfg_grant;
  logic          pick_valid_d;
  grant_t        pick_d;
  logic [18:0]   pick_addr_d;
  logic          win_req;

  assign poll_tc    = (poll_q == PW'(POLL_DIV - 1));
  assign cfg_urgent = cfg_pend_q && (age_q >= 8'(STARVE));
  assign cfg_grant  = (state_q == ST_IDLE) && pick_valid_d && (pick_d == G_CFG);

  // Fixed priority: starving poll, then program, then graphics, then poll.
  always_comb begin
    pick_valid_d = 1'b1;
    pick_d       = G_PRG;
    pick_addr_d  = {3'b000, prg_bank, prg_addr};
    if (cfg_urgent) begin
      pick_d      = G_CFG;
      pick_addr_d = CFG_ADDR;
    end else if (prg_req) begin
      pick_d      = G_PRG;
      pick_addr_d = {3'b000, prg_bank, prg_addr};
    end else if (gfx_req) begin
      pick_d      = G_GFX;
      pick_addr_d = {3'b001, gfx_bank, 1'b0, gfx_addr};
    end else if (cfg_pend_q) begin
      pick_d      = G_CFG;
      pick_addr_d = CFG_ADDR;
    end else begin
      pick_valid_d = 1'b0;
    end
  end

  // Current req level of the locked winner; the internal poll never withdraws.
  always_comb begin
    win_req = 1'b1;
    case (grant_q)
      G_PRG:   win_req = prg_req;
      G_GFX:   win_req = gfx_req;
      default: win_req = 1'b1;
    endcase
  end

  // Poll timer and age counter; a terminal count in the grant cycle re-arms pending.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      poll_q     <= '0;
      age_q      <= 8'd0;
      cfg_pend_q <= 1'b0;
    end else begin
      poll_q <= poll_tc ? '0 : poll_q + 1'b1;
      if (poll_tc)
        cfg_pend_q <= 1'b1;
      else if (cfg_grant)
        cfg_pend_q <= 1'b0;
      if (cfg_grant)
        age_q <= 8'd0;
      else if (cfg_pend_q && (age_q != 8'hFF))
        age_q <= age_q + 8'd1;
    end
  end

  // Access sequencer with registered address, acks and captured data.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= G_PRG;
      wait_q      <= 4'd0;
      dropped_q   <= 1'b0;
      sram_addr_q <= CFG_ADDR;
      prg_ack_q   <= 1'b0;
      gfx_ack_q   <= 1'b0;
      prg_data_q  <= 8'h00;
      gfx_data_q  <= 8'h00;
      scandbl_q   <= 2'b00;
      cfg_valid_q <= 1'b0;
    end else begin
      prg_ack_q <= 1'b0;
      gfx_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_d) begin
            grant_q     <= pick_d;
            sram_addr_q <= pick_addr_d;
            wait_q      <= 4'(WAIT_CYCLES - 1);
            dropped_q   <= 1'b0;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A withdrawn req anywhere in the access suppresses the ack and capture.
          if (!win_req)
            dropped_q <= 1'b1;
          if (wait_q == 4'd0) begin
            state_q <= ST_DONE;
            case (grant_q)
              G_PRG: begin
                if (win_req && !dropped_q) begin
                  prg_data_q <= sram_data;
                  prg_ack_q  <= 1'b1;
                end
              end
              G_GFX: begin
                if (win_req && !dropped_q) begin
                  gfx_data_q <= sram_data;
                  gfx_ack_q  <= 1'b1;
                end
              end
              default: begin
                scandbl_q   <= sram_data[1:0];
                cfg_valid_q <= 1'b1;
              end
            endcase
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sram_addr   = sram_addr_q;
  assign sram_we_n   = 1'b1;
  assign prg_ack     = prg_ack_q;
  assign gfx_ack     = gfx_ack_q;
  assign prg_data    = prg_data_q;
  assign gfx_data    = gfx_data_q;
  assign scandblctrl = scandbl_q;
  assign cfg_valid   = cfg_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zigzag_sram_arbiter.sv
// Directed bench for zigzag_sram_arbiter with a behavioural SRAM model.
module tb_zigzag_sram_arbiter;

  localparam logic [18:0] CFG = 19'h08FD5;

  logic        pclk = 1'b0;
  logic        reset;
  logic        prg_req, prg_bank;
  logic [14:0] prg_addr;
  logic        prg_ack;
  logic [7:0]  prg_data;
  logic        gfx_req, gfx_bank;
  logic [13:0] gfx_addr;
  logic        gfx_ack;
  logic [7:0]  gfx_data;
  logic [18:0] sram_addr;
  logic [7:0]  sram_data;
  logic        sram_we_n;
  logic [1:0]  scandblctrl;
  logic        cfg_valid;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int edge_n = 0;

  zigzag_sram_arbiter dut (
    .pclk(pclk), .reset(reset),
    .prg_req(prg_req), .prg_bank(prg_bank), .prg_addr(prg_addr),
    .prg_ack(prg_ack), .prg_data(prg_data),
    .gfx_req(gfx_req), .gfx_bank(gfx_bank), .gfx_addr(gfx_addr),
    .gfx_ack(gfx_ack), .gfx_data(gfx_data),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we_n(sram_we_n),
    .scandblctrl(scandblctrl), .cfg_valid(cfg_valid), .busy(busy)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] model_byte(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b00000, a[18:16]};
  endfunction

  assign sram_data = (sram_addr == CFG) ? 8'h02 : model_byte(sram_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    edge_n++;
  endtask

  task automatic release_reset();
    @(negedge pclk);
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          any_ack;
    int          overlap, gfx_cnt, prg_before, last_before, first_after, rise_n;
    logic [18:0] addr_at_1281;

    reset = 1'b1;
    prg_req = 1'b0; prg_bank = 1'b0; prg_addr = '0;
    gfx_req = 1'b0; gfx_bank = 1'b0; gfx_addr = '0;
    repeat (2) @(posedge pclk);
    #1;

    // Reset values
    chk("rst_sram_addr", 32'(sram_addr), 32'(CFG));
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_acks", 32'({prg_ack, gfx_ack}), 32'd0);
    chk("rst_data", 32'({prg_data, gfx_data}), 32'd0);
    chk("rst_cfg", 32'({scandblctrl, cfg_valid}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // First poll: pending after edge 1024, granted 1025, captured 1027
    release_reset();
    repeat (1026) tick();
    chk("poll_busy_1026", 32'(busy), 32'd1);
    chk("poll_addr", 32'(sram_addr), 32'(CFG));
    chk("poll_valid_early", 32'(cfg_valid), 32'd0);
    tick();
    chk("poll_valid", 32'(cfg_valid), 32'd1);
    chk("poll_scandbl", 32'(scandblctrl), 32'd2);

    // Program fetch, fresh reset
    reset = 1'b1;
    #2;
    chk("poll_reset_valid", 32'(cfg_valid), 32'd0);
    release_reset();
    repeat (3) tick();
    prg_bank = 1'b1; prg_addr = 15'h1234; prg_req = 1'b1;
    tick();
    chk("prg_addr", 32'(sram_addr), 32'h09234);
    chk("prg_busy", 32'(busy), 32'd1);
    chk("prg_ack_k", 32'(prg_ack), 32'd0);
    tick();
    chk("prg_ack_k1", 32'(prg_ack), 32'd0);
    tick();
    chk("prg_ack_k2", 32'(prg_ack), 32'd1);
    chk("prg_data", 32'(prg_data), 32'(model_byte(19'h09234)));
    prg_req = 1'b0;
    tick();
    chk("prg_ack_k3", 32'(prg_ack), 32'd0);
    chk("prg_idle", 32'(busy), 32'd0);

    // Graphics fetch
    gfx_bank = 1'b1; gfx_addr = 14'h0ABC; gfx_req = 1'b1;
    tick();
    chk("gfx_addr", 32'(sram_addr), 32'h18ABC);
    tick();
    chk("gfx_ack_k1", 32'(gfx_ack), 32'd0);
    tick();
    chk("gfx_ack_k2", 32'(gfx_ack), 32'd1);
    chk("gfx_data", 32'(gfx_data), 32'(model_byte(19'h18ABC)));
    gfx_req = 1'b0;
    tick();
    chk("gfx_ack_width", 32'(gfx_ack), 32'd0);

    // Program access afterwards must leave gfx_data alone
    prg_bank = 1'b0; prg_addr = 15'h7FFF; prg_req = 1'b1;
    repeat (3) tick();
    chk("prg2_ack", 32'(prg_ack), 32'd1);
    chk("prg2_data", 32'(prg_data), 32'h80);
    prg_req = 1'b0;
    tick();
    chk("gfx_data_held", 32'(gfx_data), 32'(model_byte(19'h18ABC)));

    // Program req withdrawn mid-access
    prg_bank = 1'b1; prg_addr = 15'h0001; prg_req = 1'b1;
    tick();
    chk("drop_addr", 32'(sram_addr), 32'h08001);
    prg_req = 1'b0;
    any_ack = 0;
    repeat (2) begin
      tick();
      if (prg_ack) any_ack++;
    end
    chk("drop_busy_done", 32'(busy), 32'd1);
    tick();
    chk("drop_no_ack", 32'(any_ack), 32'd0);
    chk("drop_data_kept", 32'(prg_data), 32'h80);
    chk("drop_idle", 32'(busy), 32'd0);

    // Reset pulse during a program access
    prg_bank = 1'b0; prg_addr = 15'h0055; prg_req = 1'b1;
    tick();
    chk("rsta_addr", 32'(sram_addr), 32'h00055);
    #2 reset = 1'b1;
    #1;
    chk("rsta_busy", 32'(busy), 32'd0);
    chk("rsta_sram_addr", 32'(sram_addr), 32'(CFG));
    chk("rsta_prg_data", 32'(prg_data), 32'd0);
    chk("rsta_gfx_data", 32'(gfx_data), 32'd0);
    @(posedge pclk);
    #1;
    chk("rsta_no_ack", 32'(prg_ack), 32'd0);
    release_reset();
    tick();
    chk("rsta_regrant", 32'(sram_addr), 32'h00055);
    tick();
    tick();
    chk("rsta_ack", 32'(prg_ack), 32'd1);
    chk("rsta_data", 32'(prg_data), 32'h55);
    prg_req = 1'b0;
    tick();

    // Starvation: prg and gfx held from reset release
    reset = 1'b1;
    prg_bank = 1'b0; prg_addr = 15'h0100; prg_req = 1'b1;
    gfx_bank = 1'b0; gfx_addr = 14'h0200; gfx_req = 1'b1;
    release_reset();
    overlap = 0; gfx_cnt = 0; prg_before = 0;
    last_before = -1; first_after = -1; rise_n = -1;
    addr_at_1281 = '0;
    for (int n = 1; n <= 1300; n++) begin
      tick();
      if (prg_ack && gfx_ack) overlap++;
      if (gfx_ack) gfx_cnt++;
      if (cfg_valid && rise_n < 0) rise_n = n;
      if (n == 1281) addr_at_1281 = sram_addr;
      if (prg_ack) begin
        if (rise_n < 0) begin
          prg_before++;
          last_before = n;
        end else if (first_after < 0) begin
          first_after = n;
        end
      end
    end
    prg_req = 1'b0;
    gfx_req = 1'b0;
    chk("starve_overlap", 32'(overlap), 32'd0);
    chk("starve_gfx_acks", 32'(gfx_cnt), 32'd0);
    chk("starve_prg_count", 32'(prg_before), 32'd320);
    chk("starve_last_prg", 32'(last_before), 32'd1279);
    chk("starve_cfg_addr", 32'(addr_at_1281), 32'(CFG));
    chk("starve_cfg_rise", 32'(rise_n), 32'd1283);
    chk("starve_scandbl", 32'(scandblctrl), 32'd2);
    chk("starve_prg_resume", 32'(first_after), 32'd1287);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
